id_stage_hz: RTL and testbench

Parametrised instruction-decode stage for the 5-stage MIPS-subset pipeline, sitting between the IF/ID and ID/EX boundaries. It holds the register file, decodes into registered ID/EX control and data, and adds the following:
- write-to-read bypass from WB
- load-use hazard detection
- stall/flush handling with bubble insertion
- an illegal-instruction flag
- a correct jal link write

---
 rtl/id_stage_hz_if.sv | 64 ++++++
 rtl/id_stage_hz.sv | 279 +++++++++++++++++++++++++++
 tb/tb_id_stage_hz.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_hz_if.sv
// -----------------------------------------------------------------------------
// id_stage_hz_if
// Bundles every non-clock/reset signal of the ID stage.
//   slave  : the decode stage itself (consumes IF/ID, WB, EX; drives ID/EX)
//   master : the surrounding pipeline / testbench
// Signal groups:
//   IF/ID   : stall, flush, if_valid, pc, ir
//   WB      : wb_we, wb_rd, wb_data
//   EX      : ex_memread, ex_rd
//   hazard  : hazard_stall (combinational load-use request to IF)
//   ID/EX   : dx_valid, mem_to_reg, reg_write, mem_read, mem_write, branch,
//             branch_ne, jump, alu_ctr, jt, dx_pc, npc, a, b, store_data,
//             imm_ext, rd, illegal
// -----------------------------------------------------------------------------
interface id_stage_hz_if #(
  parameter int XLEN = 32
) ();
  logic            stall;
  logic            flush;
  logic            if_valid;
  logic [XLEN-1:0] pc;
  logic [31:0]     ir;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            ex_memread;
  logic [4:0]      ex_rd;

  logic            hazard_stall;
  logic            dx_valid;
  logic            mem_to_reg;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic            branch;
  logic            branch_ne;
  logic            jump;
  logic [2:0]      alu_ctr;
  logic [XLEN-1:0] jt;
  logic [XLEN-1:0] dx_pc;
  logic [XLEN-1:0] npc;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] store_data;
  logic [XLEN-1:0] imm_ext;
  logic [4:0]      rd;
  logic            illegal;

  modport slave (
    input  stall, flush, if_valid, pc, ir, wb_we, wb_rd, wb_data,
           ex_memread, ex_rd,
    output hazard_stall, dx_valid, mem_to_reg, reg_write, mem_read, mem_write,
           branch, branch_ne, jump, alu_ctr, jt, dx_pc, npc, a, b,
           store_data, imm_ext, rd, illegal
  );

  modport master (
    output stall, flush, if_valid, pc, ir, wb_we, wb_rd, wb_data,
           ex_memread, ex_rd,
    input  hazard_stall, dx_valid, mem_to_reg, reg_write, mem_read, mem_write,
           branch, branch_ne, jump, alu_ctr, jt, dx_pc, npc, a, b,
           store_data, imm_ext, rd, illegal
  );
endinterface

// File: rtl/id_stage_hz.sv
// -----------------------------------------------------------------------------
// id_stage_hz
// Instruction-decode stage of a 5-stage MIPS-subset pipeline. Holds the
// register file (with WB->ID same-cycle bypass), detects load-use hazards,
// and registers decoded control/data into the ID/EX boundary with
// stall-hold and bubble insertion.
// Ports:
//   clk  : single clock
//   rst  : synchronous, active-high reset (clears ID/EX and register file)
//   bus  : id_stage_hz_if.slave, see the interface for the signal list
// Parameters:
//   XLEN     : datapath / PC width (>= 32)
//   NREG     : implemented registers (<= 32); higher indices read 0
//   LINK_REG : jal destination register
// -----------------------------------------------------------------------------
module id_stage_hz #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int LINK_REG = 31
) (
  input  logic         clk,
  input  logic         rst,
  id_stage_hz_if.slave bus
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'd0,
    OP_J     = 6'd2,
    OP_JAL   = 6'd3,
    OP_BEQ   = 6'd4,
    OP_BNE   = 6'd5,
    OP_ADDI  = 6'd8,
    OP_LW    = 6'd35,
    OP_SW    = 6'd43
  } opcode_e;

  typedef enum logic [5:0] {
    FN_JR  = 6'd8,
    FN_ADD = 6'd32,
    FN_SUB = 6'd34,
    FN_AND = 6'd36,
    FN_OR  = 6'd37,
    FN_XOR = 6'd38,
    FN_SLT = 6'd42
  } funct_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_CMP = 3'd5,
    ALU_XOR = 3'd6
  } alu_e;

  typedef struct packed {
    logic            valid;
    logic            mem_to_reg;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            branch_ne;
    logic            jump;
    logic            illegal;
    logic [2:0]      alu_ctr;
    logic [4:0]      rd;
    logic [XLEN-1:0] jt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] imm_ext;
  } idex_t;

  // ---------------------------------------------------------------------------
  // Field extraction
  // ---------------------------------------------------------------------------
  logic [5:0]      w_op;
  logic [5:0]      w_fn;
  logic [4:0]      w_rs;
  logic [4:0]      w_rt;
  logic [XLEN-1:0] w_imm_ext;
  logic [XLEN-1:0] w_pc4;
  logic            w_unused;

  assign w_op      = bus.ir[31:26];
  assign w_fn      = bus.ir[5:0];
  assign w_rs      = bus.ir[25:21];
  assign w_rt      = bus.ir[20:16];
  assign w_imm_ext = {{(XLEN-16){bus.ir[15]}}, bus.ir[15:0]};
  assign w_pc4     = bus.pc + XLEN'(4);   // wraps modulo 2^XLEN
  assign w_unused  = ^bus.ir[10:6];       // shamt: no shift ops in this subset

  // ---------------------------------------------------------------------------
  // Register file. Entries at or above NREG do not exist and read as zero.
  // ---------------------------------------------------------------------------
  logic            w_wb_wr;
  logic [XLEN-1:0] w_rf [32];

  // A write to r0 or to a non-existent register is dropped, so it must not
  // be bypassed either.
  assign w_wb_wr = bus.wb_we && (bus.wb_rd != 5'd0) && (int'(bus.wb_rd) < NREG);
  assign w_rf[0] = '0;

  for (genvar gi = 1; gi < 32; gi++) begin : g_rf
    if (gi < NREG) begin : g_impl
      logic [XLEN-1:0] r_q;
      // NOTE: the register file is cleared on reset because software may read
      // a register before writing it and expects 0; this rules out RAM macros.
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process evaluation order.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_q <= '0;
        end else if (w_wb_wr && (bus.wb_rd == 5'(gi))) begin
          r_q <= bus.wb_data;
        end
      end
      assign w_rf[gi] = r_q;
    end else begin : g_none
      assign w_rf[gi] = '0;
    end
  end

  // WB result written this edge is forwarded so ID never reads a stale value.
  logic [XLEN-1:0] w_rs_val;
  logic [XLEN-1:0] w_rt_val;

  assign w_rs_val = (w_wb_wr && (bus.wb_rd == w_rs)) ? bus.wb_data : w_rf[w_rs];
  assign w_rt_val = (w_wb_wr && (bus.wb_rd == w_rt)) ? bus.wb_data : w_rf[w_rt];

  // ---------------------------------------------------------------------------
  // Load-use hazard: a lw in EX produces its value too late for this decode.
  // ---------------------------------------------------------------------------
  logic w_uses_rt;
  logic w_hazard;

  assign w_uses_rt = (w_op == OP_RTYPE) || (w_op == OP_BEQ) ||
                     (w_op == OP_BNE)   || (w_op == OP_SW);
  assign w_hazard  = !rst && bus.if_valid && bus.ex_memread &&
                     (bus.ex_rd != 5'd0) &&
                     ((bus.ex_rd == w_rs) || (w_uses_rt && (bus.ex_rd == w_rt)));

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  idex_t w_dec;
  idex_t w_bubble;

  // NOTE: every field gets a default before the case so no path leaves a
  // combinational output unassigned, which would otherwise infer a latch.
  always_comb begin
    w_dec            = '0;
    w_dec.valid      = 1'b1;
    w_dec.pc         = bus.pc;
    w_dec.npc        = w_pc4;
    w_dec.a          = w_rs_val;
    w_dec.b          = w_rt_val;
    w_dec.store_data = w_rt_val;
    w_dec.imm_ext    = w_imm_ext;
    w_dec.alu_ctr    = ALU_ADD;
    w_dec.jt         = {w_pc4[XLEN-1:28], bus.ir[25:0], 2'b00};

    case (w_op)
      OP_RTYPE: begin
        w_dec.rd        = bus.ir[15:11];
        w_dec.reg_write = 1'b1;
        case (w_fn)
          FN_ADD:  w_dec.alu_ctr = ALU_ADD;
          FN_SUB:  w_dec.alu_ctr = ALU_SUB;
          FN_AND:  w_dec.alu_ctr = ALU_AND;
          FN_OR:   w_dec.alu_ctr = ALU_OR;
          FN_XOR:  w_dec.alu_ctr = ALU_XOR;
          FN_SLT:  w_dec.alu_ctr = ALU_SLT;
          FN_JR: begin
            w_dec.rd        = 5'd0;
            w_dec.reg_write = 1'b0;
            w_dec.jump      = 1'b1;
            w_dec.jt        = w_rs_val;
          end
          default: begin
            w_dec.rd        = 5'd0;
            w_dec.reg_write = 1'b0;
            w_dec.illegal   = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        w_dec.b          = w_imm_ext;
        w_dec.rd         = w_rt;
        w_dec.mem_read   = 1'b1;
        w_dec.mem_to_reg = 1'b1;
        w_dec.reg_write  = 1'b1;
      end
      OP_SW: begin
        w_dec.b         = w_imm_ext;
        w_dec.mem_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        w_dec.branch    = 1'b1;
        w_dec.branch_ne = w_op[0];
        w_dec.alu_ctr   = ALU_CMP;
      end
      OP_ADDI: begin
        w_dec.b         = w_imm_ext;
        w_dec.rd        = w_rt;
        w_dec.reg_write = 1'b1;
      end
      OP_J: begin
        w_dec.jump = 1'b1;
      end
      OP_JAL: begin
        // Link value travels down the ALU as pc+4+0; WB does the write.
        w_dec.jump      = 1'b1;
        w_dec.rd        = 5'(LINK_REG);
        w_dec.a         = w_pc4;
        w_dec.b         = '0;
        w_dec.reg_write = 1'b1;
      end
      default: begin
        w_dec.illegal = 1'b1;
      end
    endcase
  end

  // A bubble keeps the decoded data fields (don't-care) but kills every
  // control that could change architectural state or redirect fetch.
  always_comb begin
    w_bubble           = w_dec;
    w_bubble.valid     = 1'b0;
    w_bubble.reg_write = 1'b0;
    w_bubble.mem_read  = 1'b0;
    w_bubble.mem_write = 1'b0;
    w_bubble.branch    = 1'b0;
    w_bubble.jump      = 1'b0;
    w_bubble.illegal   = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // ID/EX register: rst > stall (hold) > bubble > normal load
  // ---------------------------------------------------------------------------
  idex_t r_dx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dx <= '0;
    end else if (bus.stall) begin
      r_dx <= r_dx;
    end else if (bus.flush || !bus.if_valid || w_hazard) begin
      r_dx <= w_bubble;
    end else begin
      r_dx <= w_dec;
    end
  end

  assign bus.hazard_stall = w_hazard;
  assign bus.dx_valid     = r_dx.valid;
  assign bus.mem_to_reg   = r_dx.mem_to_reg;
  assign bus.reg_write    = r_dx.reg_write;
  assign bus.mem_read     = r_dx.mem_read;
  assign bus.mem_write    = r_dx.mem_write;
  assign bus.branch       = r_dx.branch;
  assign bus.branch_ne    = r_dx.branch_ne;
  assign bus.jump         = r_dx.jump;
  assign bus.alu_ctr      = r_dx.alu_ctr;
  assign bus.jt           = r_dx.jt;
  assign bus.dx_pc        = r_dx.pc;
  assign bus.npc          = r_dx.npc;
  assign bus.a            = r_dx.a;
  assign bus.b            = r_dx.b;
  assign bus.store_data   = r_dx.store_data;
  assign bus.imm_ext      = r_dx.imm_ext;
  assign bus.rd           = r_dx.rd;
  assign bus.illegal      = r_dx.illegal;

endmodule

// File: tb/tb_id_stage_hz.sv
// -----------------------------------------------------------------------------
// tb_id_stage_hz
// Directed, self-checking bench for id_stage_hz. u_dut0 uses the default
// 32-register configuration; u_dut16 uses NREG=16 for the missing-register
// cases. Inputs change 1 ns after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_id_stage_hz;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  id_stage_hz_if #(.XLEN(32)) bus0 ();
  id_stage_hz_if #(.XLEN(32)) bus16 ();

  id_stage_hz #(.XLEN(32), .NREG(32), .LINK_REG(31)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  id_stage_hz #(.XLEN(32), .NREG(16), .LINK_REG(31)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(int op, int tgt);
    return {6'(op), 26'(tgt)};
  endfunction

  task automatic idle0();
    bus0.stall = 0; bus0.flush = 0; bus0.if_valid = 0;
    bus0.pc = 32'h0; bus0.ir = 32'h0;
    bus0.wb_we = 0; bus0.wb_rd = 0; bus0.wb_data = 0;
    bus0.ex_memread = 0; bus0.ex_rd = 0;
  endtask

  // {fn, expected alu_ctr} for the R-type ALU table
  logic [5:0] fn_tab  [5] = '{6'd34, 6'd36, 6'd37, 6'd38, 6'd42};
  logic [2:0] alu_tab [5] = '{3'd1,  3'd2,  3'd3,  3'd6,  3'd4};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle0();
    bus16.stall = 0; bus16.flush = 0; bus16.if_valid = 0;
    bus16.pc = 0; bus16.ir = 0; bus16.wb_we = 0; bus16.wb_rd = 0;
    bus16.wb_data = 0; bus16.ex_memread = 0; bus16.ex_rd = 0;
    rst = 1;
    tick(); tick();
    rst = 0;

    // ---------------- random traffic, then reset ----------------
    bus0.wb_we = 1; bus0.wb_rd = 5; bus0.wb_data = 32'hCAFE_0005;
    bus0.if_valid = 1; bus0.ir = enc_r(1, 2, 3, 32);
    tick();
    for (int i = 0; i < 6; i++) begin
      bus0.ir = $urandom; bus0.pc = $urandom;
      bus0.wb_we = 1; bus0.wb_rd = 5'($urandom); bus0.wb_data = $urandom;
      bus0.ex_memread = 1'($urandom); bus0.ex_rd = 5'($urandom);
      tick();
    end
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      bus0.ir = {$urandom} | 32'h00E0_0000;   // rs = 7
      bus0.ir[25:21] = 5'd7;
      bus0.ex_memread = 1; bus0.ex_rd = 5'd7;
      bus0.wb_we = 1; bus0.wb_rd = 5; bus0.wb_data = $urandom;
      tick();
    end
    check("rst_hazard_stall", bus0.hazard_stall, 0);
    check("rst_dx_valid", bus0.dx_valid, 0);
    check("rst_ctrl", {bus0.mem_to_reg, bus0.reg_write, bus0.mem_read,
                       bus0.mem_write, bus0.branch, bus0.branch_ne,
                       bus0.jump, bus0.illegal}, 0);
    check("rst_alu_ctr", bus0.alu_ctr, 0);
    check("rst_rd", bus0.rd, 0);
    check("rst_a", bus0.a, 0);
    check("rst_b", bus0.b, 0);
    check("rst_jt", bus0.jt, 0);
    check("rst_dx_pc", bus0.dx_pc, 0);
    check("rst_npc", bus0.npc, 0);
    check("rst_store_data", bus0.store_data, 0);
    check("rst_imm_ext", bus0.imm_ext, 0);
    rst = 0;
    idle0();
    bus0.if_valid = 1; bus0.ir = enc_r(5, 0, 7, 32);   // add r7,r5,r0
    tick();
    check("rst_r5_reads_0", bus0.a, 0);
    check("rst_then_valid", bus0.dx_valid, 1);

    // ---------------- WB bypass on add ----------------
    bus0.if_valid = 0; bus0.wb_we = 1; bus0.wb_rd = 6; bus0.wb_data = 7;
    tick();
    bus0.if_valid = 1; bus0.pc = 32'h100;
    bus0.wb_rd = 5; bus0.wb_data = 32'h1234;
    bus0.ir = enc_r(5, 6, 3, 32);                      // add r3,r5,r6
    tick();
    check("byp_a", bus0.a, 32'h1234);
    check("byp_b", bus0.b, 7);
    check("byp_rd", bus0.rd, 3);
    check("byp_reg_write", bus0.reg_write, 1);
    check("byp_alu", bus0.alu_ctr, 0);
    check("byp_npc", bus0.npc, 32'h104);
    check("byp_dx_pc", bus0.dx_pc, 32'h100);
    bus0.wb_we = 0;

    // ---------------- R-type ALU codes ----------------
    for (int i = 0; i < 5; i++) begin
      bus0.ir = enc_r(5, 6, 2, int'(fn_tab[i]));
      tick();
      check($sformatf("alu_fn%0d", fn_tab[i]), bus0.alu_ctr, alu_tab[i]);
      check($sformatf("alu_rw%0d", fn_tab[i]), bus0.reg_write, 1);
    end
    check("rf_r5_held", bus0.a, 32'h1234);

    // ---------------- load-use hazard ----------------
    bus0.ex_memread = 1; bus0.ex_rd = 4;
    bus0.ir = enc_r(1, 4, 2, 34);                      // sub r2,r1,r4
    #1 check("hz_rt_stall", bus0.hazard_stall, 1);
    tick();
    check("hz_bubble_valid", bus0.dx_valid, 0);
    check("hz_bubble_rw", bus0.reg_write, 0);
    bus0.ex_memread = 0;
    #1 check("hz_released", bus0.hazard_stall, 0);
    tick();
    check("hz_after_valid", bus0.dx_valid, 1);
    check("hz_after_rd", bus0.rd, 2);
    check("hz_after_alu", bus0.alu_ctr, 1);
    bus0.ex_memread = 1; bus0.ex_rd = 4;
    bus0.ir = enc_i(8, 1, 4, 5);                       // addi: rt not a source
    #1 check("hz_addi_rt", bus0.hazard_stall, 0);
    bus0.ex_rd = 1;
    #1 check("hz_addi_rs", bus0.hazard_stall, 1);
    bus0.ex_rd = 0; bus0.ir = enc_r(0, 0, 2, 32);
    #1 check("hz_r0", bus0.hazard_stall, 0);
    bus0.ex_memread = 0;

    // ---------------- jal / jr ----------------
    bus0.pc = 32'h0040_0010; bus0.ir = enc_j(3, 'h100);
    tick();
    check("jal_jump", bus0.jump, 1);
    check("jal_jt", bus0.jt, 32'h0000_0400);
    check("jal_rd", bus0.rd, 31);
    check("jal_a", bus0.a, 32'h0040_0014);
    check("jal_b", bus0.b, 0);
    check("jal_rw", bus0.reg_write, 1);
    bus0.wb_we = 1; bus0.wb_rd = 9; bus0.wb_data = 32'hDEAD_BEE0;
    bus0.ir = enc_r(9, 0, 0, 8);                       // jr r9 (bypassed)
    tick();
    check("jr_jump", bus0.jump, 1);
    check("jr_jt", bus0.jt, 32'hDEAD_BEE0);
    check("jr_rw", bus0.reg_write, 0);
    bus0.wb_we = 0;

    // ---------------- lw / sw / bne ----------------
    bus0.ir = enc_i(35, 5, 8, -4);
    tick();
    check("lw_b", bus0.b, 32'hFFFF_FFFC);
    check("lw_imm", bus0.imm_ext, 32'hFFFF_FFFC);
    check("lw_rd", bus0.rd, 8);
    check("lw_ctrl", {bus0.mem_read, bus0.mem_to_reg, bus0.reg_write,
                      bus0.mem_write}, 4'b1110);
    bus0.ir = enc_i(43, 5, 6, 8);
    tick();
    check("sw_store", bus0.store_data, 7);
    check("sw_b", bus0.b, 8);
    check("sw_ctrl", {bus0.mem_write, bus0.reg_write, bus0.mem_read}, 3'b100);
    bus0.ir = enc_i(5, 5, 6, 16);
    tick();
    check("bne_ctrl", {bus0.branch, bus0.branch_ne, bus0.jump}, 3'b110);
    check("bne_alu", bus0.alu_ctr, 5);
    check("bne_ab", {bus0.a[15:0], bus0.b[15:0]}, 32'h1234_0007);

    // ---------------- stall / flush / illegal ----------------
    bus0.stall = 1; bus0.flush = 1; bus0.ir = enc_r(1, 2, 3, 32);
    tick();
    check("stall_hold_ctrl", {bus0.dx_valid, bus0.branch, bus0.branch_ne,
                              bus0.reg_write}, 4'b1110);
    check("stall_hold_alu", bus0.alu_ctr, 5);
    bus0.stall = 0;
    tick();
    check("flush_valid", bus0.dx_valid, 0);
    check("flush_ctrl", {bus0.reg_write, bus0.branch, bus0.jump}, 0);
    bus0.flush = 0; bus0.ir = enc_i(4, 5, 6, 0);
    tick();
    check("beq_ctrl", {bus0.branch, bus0.branch_ne}, 2'b10);
    bus0.ir = {6'h3F, 26'h0};
    tick();
    check("ill_op", {bus0.illegal, bus0.dx_valid, bus0.reg_write,
                     bus0.jump, bus0.branch}, 5'b11000);
    bus0.ir = enc_r(1, 2, 3, 'h3F);
    tick();
    check("ill_fn", {bus0.illegal, bus0.dx_valid, bus0.reg_write}, 3'b110);

    // ---------------- j and PC wrap ----------------
    bus0.pc = 32'hF000_0000; bus0.ir = enc_j(2, 3);
    tick();
    check("j_jt", bus0.jt, 32'hF000_000C);
    check("j_rw", {bus0.jump, bus0.reg_write}, 2'b10);
    bus0.pc = 32'hFFFF_FFFC; bus0.ir = enc_j(2, 1);
    tick();
    check("wrap_npc", bus0.npc, 0);
    check("wrap_jt", bus0.jt, 32'h4);

    // ---------------- !if_valid bubble ----------------
    bus0.if_valid = 0; bus0.ir = enc_r(1, 4, 2, 32);
    bus0.ex_memread = 1; bus0.ex_rd = 4;
    #1 check("nv_no_hazard", bus0.hazard_stall, 0);
    tick();
    check("nv_bubble", {bus0.dx_valid, bus0.reg_write}, 0);
    idle0();

    // ---------------- NREG = 16 ----------------
    bus16.if_valid = 1; bus16.wb_we = 1; bus16.wb_rd = 20;
    bus16.wb_data = 32'hAAAA; bus16.ir = enc_i(8, 0, 1, -1);
    tick();
    check("n16_addi_b", bus16.b, 32'hFFFF_FFFF);
    check("n16_addi_a", bus16.a, 0);
    bus16.wb_rd = 3; bus16.wb_data = 32'h55;
    tick();
    bus16.wb_we = 0; bus16.ir = enc_r(20, 3, 1, 32);
    tick();
    check("n16_r20_zero", bus16.a, 0);
    check("n16_r3", bus16.b, 32'h55);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
